// File: rtl/icache_refill_pkg.sv
// Shared icache refill types and constants.
// State encoding, beat count and line word-slice helpers.
package icache_refill_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int BEATS  = 4;
  localparam int WORD_W = 32;
  localparam int LINE_W = BEATS * WORD_W;

  // Word 0 sits in the most significant slice of the line.
  function automatic int word_hi(input int n);
    return LINE_W - 1 - WORD_W * n;
  endfunction

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: one wrapping 4-beat burst per miss,
// per-word valids for early critical-word forwarding, one-cycle line write.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] last_addr,
  output logic              data0_valid,
  output logic              data1_valid,
  output logic              data2_valid,
  output logic              data3_valid,
  output logic [127:0]      wdata,
  output logic              done,
  output logic              cache_we,
  output logic              busy
);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_sw;
  logic [1:0]          r_cnt;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [BEATS-1:0]    r_valid;
  logic                w_accept;
  logic                w_beat;
  logic [1:0]          w_word;
  logic                w_mem_req;
  logic                w_busy;
  logic                w_done;

  assign w_accept = (r_state == S_IDLE) && miss;
  assign w_beat   = (r_state == S_FILL) && mem_rvalid;
  assign w_word   = r_sw + r_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_mem_req = 1'b0;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (miss) w_next = S_REQ;
      end
      S_REQ: begin
        w_mem_req = 1'b1;
        if (mem_gnt) w_next = S_FILL;
      end
      S_FILL: begin
        if (mem_rvalid && (r_cnt == 2'd3)) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw        <= '0;
      r_cnt       <= '0;
      r_last_addr <= '0;
      r_mem_addr  <= '0;
      r_wdata     <= '0;
      r_valid     <= '0;
    end else begin
      if (w_accept) begin
        r_sw        <= miss_addr[1:0];
        r_cnt       <= '0;
        r_last_addr <= miss_addr;
        r_mem_addr  <= miss_addr;
        r_valid     <= '0;
      end
      if (w_beat) begin
        for (int n = 0; n < BEATS; n++) begin
          if (w_word == 2'(n)) begin
            r_wdata[word_hi(n) -: WORD_W] <= mem_rdata;
            r_valid[n]                    <= 1'b1;
          end
        end
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  assign mem_req     = w_mem_req;
  assign mem_addr    = r_mem_addr;
  assign last_addr   = r_last_addr;
  assign data0_valid = r_valid[0];
  assign data1_valid = r_valid[1];
  assign data2_valid = r_valid[2];
  assign data3_valid = r_valid[3];
  assign wdata       = r_wdata;
  assign done        = w_done;
  assign cache_we    = w_done;
  assign busy        = w_busy;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill.
// Hand-computed expectations for wrap order, stalls, ignores and reset.
module tb_icache_refill;

  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              reset;
  logic              miss;
  logic [ADDR_W-1:0] miss_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] last_addr;
  logic              data0_valid;
  logic              data1_valid;
  logic              data2_valid;
  logic              data3_valid;
  logic [127:0]      wdata;
  logic              done;
  logic              cache_we;
  logic              busy;

  int checks = 0;
  int errors = 0;

  icache_refill #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .miss       (miss),
    .miss_addr  (miss_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .last_addr  (last_addr),
    .data0_valid(data0_valid),
    .data1_valid(data1_valid),
    .data2_valid(data2_valid),
    .data3_valid(data3_valid),
    .wdata      (wdata),
    .done       (done),
    .cache_we   (cache_we),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] vld();
    return {data0_valid, data1_valid, data2_valid, data3_valid};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    step();
    mem_rvalid = 1'b0;
  endtask

  task automatic start(input logic [ADDR_W-1:0] a);
    miss      = 1'b1;
    miss_addr = a;
    step();
    miss      = 1'b0;
    chk("req_up", mem_req, 1'b1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("req_dn", mem_req, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, mem_req, 1'b0);
    chk({tag, "_maddr"}, mem_addr, 18'h0);
    chk({tag, "_laddr"}, last_addr, 18'h0);
    chk({tag, "_wdata"}, wdata, 128'h0);
    chk({tag, "_vld"}, vld(), 4'b0000);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_we"}, cache_we, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    miss       = 1'b0;
    miss_addr  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    step();
    step();
    reset = 1'b0;
    chk_reset_vals("rst");

    // Start word 0, immediate grant, back-to-back beats
    miss      = 1'b1;
    miss_addr = 18'h00014;
    step();
    miss = 1'b0;
    chk("t1_req", mem_req, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_maddr", mem_addr, 18'h00014);
    chk("t1_laddr", last_addr, 18'h00014);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("t1_req_dn", mem_req, 1'b0);
    beat(32'hA000_00A0);
    chk("t1_v0", vld(), 4'b1000);
    chk("t1_w0", wdata[127:96], 32'hA000_00A0);
    beat(32'hA111_00A1);
    chk("t1_v1", vld(), 4'b1100);
    chk("t1_w1", wdata[95:64], 32'hA111_00A1);
    beat(32'hA222_00A2);
    chk("t1_v2", vld(), 4'b1110);
    chk("t1_done_early", done, 1'b0);
    beat(32'hA333_00A3);
    chk("t1_v3", vld(), 4'b1111);
    chk("t1_done", done, 1'b1);
    chk("t1_we", cache_we, 1'b1);
    chk("t1_line", wdata,
        {32'hA000_00A0, 32'hA111_00A1, 32'hA222_00A2, 32'hA333_00A3});
    step();
    chk("t1_done_off", done, 1'b0);
    chk("t1_idle", busy, 1'b0);
    chk("t1_hold", wdata[31:0], 32'hA333_00A3);

    // Start word 3 wraps to word 0
    start(18'h00017);
    chk("t2_maddr", mem_addr, 18'h00017);
    beat(32'hB000_00B0);
    chk("t2_v0", vld(), 4'b0001);
    chk("t2_w3", wdata[31:0], 32'hB000_00B0);
    beat(32'hB111_00B1);
    chk("t2_v1", vld(), 4'b1001);
    chk("t2_w0", wdata[127:96], 32'hB111_00B1);
    beat(32'hB222_00B2);
    chk("t2_v2", vld(), 4'b1101);
    chk("t2_w1", wdata[95:64], 32'hB222_00B2);
    beat(32'hB333_00B3);
    chk("t2_done", done, 1'b1);
    chk("t2_line", wdata,
        {32'hB111_00B1, 32'hB222_00B2, 32'hB333_00B3, 32'hB000_00B0});
    step();

    // Grant after 3 extra cycles, gap between beats 1 and 2
    miss      = 1'b1;
    miss_addr = 18'h00020;
    step();
    miss = 1'b0;
    chk("t3_req_c1", mem_req, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_req_hold", mem_req, 1'b1);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("t3_req_dn", mem_req, 1'b0);
    beat(32'hC000_0000);
    beat(32'hC000_0001);
    chk("t3_v1", vld(), 4'b1100);
    step();
    chk("t3_gap_v2", data2_valid, 1'b0);
    chk("t3_gap_busy", busy, 1'b1);
    beat(32'hC000_0002);
    chk("t3_v2", data2_valid, 1'b1);
    chk("t3_nodone", done, 1'b0);
    beat(32'hC000_0003);
    chk("t3_done", done, 1'b1);
    step();
    chk("t3_single", done, 1'b0);

    // Miss during FILL, miss in DONE and beat in IDLE all ignored
    start(18'h00031);
    beat(32'hD000_0000);
    miss      = 1'b1;
    miss_addr = 18'h3FF00;
    beat(32'hD000_0001);
    chk("t4_laddr", last_addr, 18'h00031);
    chk("t4_v", vld(), 4'b0110);
    chk("t4_noreq", mem_req, 1'b0);
    beat(32'hD000_0002);
    miss = 1'b0;
    beat(32'hD000_0003);
    chk("t4_done", done, 1'b1);
    chk("t4_line", wdata,
        {32'hD000_0003, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002});
    miss      = 1'b1;
    miss_addr = 18'h00040;
    step();
    miss = 1'b0;
    chk("t4_donemiss_busy", busy, 1'b0);
    chk("t4_donemiss_laddr", last_addr, 18'h00031);
    beat(32'hDEAD_BEEF);
    chk("t4_idle_wdata", wdata,
        {32'hD000_0003, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002});
    chk("t4_idle_vld", vld(), 4'b1111);
    chk("t4_idle_busy", busy, 1'b0);

    // Reset mid-burst, stray beats dropped, then a clean refill
    start(18'h00008);
    beat(32'hE000_0000);
    beat(32'hE000_0001);
    chk("t5_v", vld(), 4'b1100);
    reset = 1'b1;
    beat(32'hE000_0002);
    reset = 1'b0;
    chk_reset_vals("t5_rst");
    beat(32'hE000_0003);
    chk("t5_stray_wdata", wdata, 128'h0);
    chk("t5_stray_vld", vld(), 4'b0000);
    start(18'h0000E);
    beat(32'hF000_0000);
    chk("t5_v0", vld(), 4'b0010);
    beat(32'hF000_0001);
    beat(32'hF000_0002);
    beat(32'hF000_0003);
    chk("t5_done", done, 1'b1);
    chk("t5_line", wdata,
        {32'hF000_0002, 32'hF000_0003, 32'hF000_0000, 32'hF000_0001});
    chk("t5_laddr", last_addr, 18'h0000E);
    step();
    chk("t5_end", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
